// File: rtl/mine_count_calc.sv
// mine_count_calc
// Walks every cell of a ROWS x COLS minefield, reads the cell and its eight
// neighbours from a 1-cycle-latency mine bitmap memory, and writes each
// cell's adjacent-mine count (or 9 if the cell itself is a mine) into a
// count memory. Also reports the total number of mines, saturating at 63.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous active-low reset
//   start           level; begins a pass when sampled in IDLE
//   mine_mem_addr   read address into the mine bitmap
//   mine_mem_q      mine bit for the address presented last cycle
//   count_mem_addr  write address into the count memory
//   count_mem_data  0..8 adjacent mines, or 9 when the cell is a mine
//   count_mem_wren  write strobe, one cycle per cell
//   busy            high from SCAN entry through the last WRITE
//   done            one-cycle pulse when the pass completes
//   mine_count      mines found in the pass, saturating at 63
module mine_count_calc #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] mine_mem_addr,
  input  logic       mine_mem_q,
  output logic [7:0] count_mem_addr,
  output logic [3:0] count_mem_data,
  output logic       count_mem_wren,
  output logic       busy,
  output logic       done,
  output logic [5:0] mine_count
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, WRITE, DONE} state_t;

  localparam logic [8:0] LAST_ROW = 9'(ROWS - 1);
  localparam logic [8:0] LAST_COL = 9'(COLS - 1);

  state_t     state, next_state;
  logic [8:0] row, col;
  logic [3:0] k;
  logic [3:0] acc;
  logic       self_mine;
  logic       valid_d;
  logic [3:0] k_d;

  int         dr, dc, nr, nc;
  logic       in_bounds;
  logic       last_cell;
  logic [7:0] cell_addr;

  // Neighbour offset for the current k, bounds check on row and column
  // independently so edges never wrap, plus next-state and output decode.
  always_comb begin
    next_state     = state;
    dr             = 0;
    dc             = 0;
    mine_mem_addr  = 8'd0;
    count_mem_addr = 8'd0;
    count_mem_data = 4'd0;
    count_mem_wren = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;

    case (k)
      4'd1:    begin dr = -1; dc = -1; end
      4'd2:    begin dr = -1; dc =  0; end
      4'd3:    begin dr = -1; dc =  1; end
      4'd4:    begin dr =  0; dc = -1; end
      4'd5:    begin dr =  0; dc =  1; end
      4'd6:    begin dr =  1; dc = -1; end
      4'd7:    begin dr =  1; dc =  0; end
      4'd8:    begin dr =  1; dc =  1; end
      default: begin dr =  0; dc =  0; end
    endcase

    nr        = int'(row) + dr;
    nc        = int'(col) + dc;
    in_bounds = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
    cell_addr = 8'(int'(row) * COLS + int'(col));
    last_cell = (row == LAST_ROW) && (col == LAST_COL);

    case (state)
      IDLE: begin
        if (start) next_state = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        // Out-of-bounds reads still go to a legal address; the bit is dropped.
        mine_mem_addr = in_bounds ? 8'(nr * COLS + nc) : cell_addr;
        if (k == 4'd8) next_state = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        next_state = WRITE;
      end
      WRITE: begin
        busy           = 1'b1;
        count_mem_wren = 1'b1;
        count_mem_addr = cell_addr;
        count_mem_data = self_mine ? 4'd9 : acc;
        next_state     = last_cell ? DONE : SCAN;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and datapath. The read bit arrives a cycle after its
  // address, so the in-bounds flag and k travel with it through valid_d/k_d.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      row        <= 9'd0;
      col        <= 9'd0;
      k          <= 4'd0;
      acc        <= 4'd0;
      self_mine  <= 1'b0;
      valid_d    <= 1'b0;
      k_d        <= 4'd0;
      mine_count <= 6'd0;
    end else begin
      state   <= next_state;
      valid_d <= (state == SCAN) && in_bounds;
      k_d     <= k;

      if (valid_d) begin
        if (k_d == 4'd0) self_mine <= mine_mem_q;
        else             acc       <= acc + {3'b000, mine_mem_q};
      end

      case (state)
        IDLE: begin
          if (start) begin
            row        <= 9'd0;
            col        <= 9'd0;
            k          <= 4'd0;
            acc        <= 4'd0;
            self_mine  <= 1'b0;
            mine_count <= 6'd0;
          end
        end
        SCAN: begin
          k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
        end
        WRITE: begin
          if (self_mine && (mine_count != 6'd63)) mine_count <= mine_count + 6'd1;
          acc       <= 4'd0;
          self_mine <= 1'b0;
          if (!last_cell) begin
            if (col == LAST_COL) begin
              col <= 9'd0;
              row <= row + 9'd1;
            end else begin
              col <= col + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_count_calc.sv
// tb_mine_count_calc
// Table-driven bench for mine_count_calc: each table row loads a bitmap
// pattern, an independent neighbour-count model pushes the expected writes
// into a scoreboard queue, and a monitor pops and compares every write.
// Hand-written sequences cover start-while-busy, mid-pass reset and start
// held high across DONE.
module tb_mine_count_calc;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int NCELL = ROWS * COLS;
  localparam int PASS_CYCLES = 2817;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] mine_mem_addr;
  logic       mine_mem_q;
  logic [7:0] count_mem_addr;
  logic [3:0] count_mem_data;
  logic       count_mem_wren;
  logic       busy;
  logic       done;
  logic [5:0] mine_count;

  mine_count_calc #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mine_mem_addr  (mine_mem_addr),
    .mine_mem_q     (mine_mem_q),
    .count_mem_addr (count_mem_addr),
    .count_mem_data (count_mem_data),
    .count_mem_wren (count_mem_wren),
    .busy           (busy),
    .done           (done),
    .mine_count     (mine_count)
  );

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
  } wr_t;

  typedef struct {
    int kind;
    int pos;
    int exp_mc;
  } vec_t;

  logic mine_bits [NCELL];
  int   got_data  [NCELL];
  wr_t  exp_q [$];
  vec_t vecs [6];
  int   n_vec;
  int   n_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bitmap memory with one cycle of read latency.
  always @(posedge clk) mine_mem_q <= mine_bits[mine_mem_addr];

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pattern kinds: 0 empty, 1 single mine at pos, 2 full, 3 every 5th cell,
  // 4 checkerboard.
  task automatic apply_stimulus(input int kind, input int pos);
    for (int c = 0; c < NCELL; c++) begin
      case (kind)
        1:       mine_bits[c] = (c == pos);
        2:       mine_bits[c] = 1'b1;
        3:       mine_bits[c] = ((c % 5) == 0);
        4:       mine_bits[c] = ((((c / COLS) + (c % COLS)) % 2) == 0);
        default: mine_bits[c] = 1'b0;
      endcase
      got_data[c] = 15;
    end
  endtask

  task automatic build_expected();
    for (int c = 0; c < NCELL; c++) begin
      int r, cl, cnt;
      wr_t w;
      r   = c / COLS;
      cl  = c % COLS;
      cnt = 0;
      if (mine_bits[c]) begin
        cnt = 9;
      end else begin
        for (int a = -1; a <= 1; a++)
          for (int b = -1; b <= 1; b++)
            if (!(a == 0 && b == 0) && (r + a >= 0) && (r + a < ROWS) &&
                (cl + b >= 0) && (cl + b < COLS) && mine_bits[(r + a) * COLS + cl + b])
              cnt++;
      end
      w.addr = 8'(c);
      w.data = 4'(cnt);
      exp_q.push_back(w);
    end
  endtask

  // Scoreboard monitor: every write must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst && count_mem_wren) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write",
                 count_mem_addr, count_mem_data);
      end else begin
        e = exp_q.pop_front();
        check_output("write_addr", int'(count_mem_addr), int'(e.addr));
        check_output("write_data", int'(count_mem_data), int'(e.data));
        got_data[count_mem_addr] = int'(count_mem_data);
      end
    end
  end

  // Called #1 after the start-sampling edge; returns the cycle in which done
  // was seen (cycle 1 begins at that edge). poke pulses start in that cycle.
  task automatic wait_done(input int poke, input logic keep, output int cyc);
    cyc = 1;
    start = keep;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc >= 4000) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected %0d",
                 cyc, PASS_CYCLES);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      start = keep || (cyc == poke);
    end
  endtask

  task automatic run_pass(input int poke, output int cyc);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(poke, 1'b0, cyc);
  endtask

  initial begin
    int cyc;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b0;
    start  = 1'b0;
    apply_stimulus(0, 0);

    vecs[0] = '{kind: 0, pos: 0,   exp_mc: 0};
    vecs[1] = '{kind: 1, pos: 0,   exp_mc: 1};
    vecs[2] = '{kind: 1, pos: 15,  exp_mc: 1};
    vecs[3] = '{kind: 2, pos: 0,   exp_mc: 63};
    vecs[4] = '{kind: 3, pos: 0,   exp_mc: 52};
    vecs[5] = '{kind: 4, pos: 0,   exp_mc: 63};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy",  int'(busy), 0);
    check_output("reset_done",  int'(done), 0);
    check_output("reset_wren",  int'(count_mem_wren), 0);
    check_output("reset_mc",    int'(mine_count), 0);
    check_output("reset_raddr", int'(mine_mem_addr), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].kind, vecs[i].pos);
      build_expected();
      run_pass(-1, cyc);
      check_output("done_cycle", cyc, PASS_CYCLES);
      check_output("mine_count", int'(mine_count), vecs[i].exp_mc);
      check_output("queue_left", exp_q.size(), 0);
      if (vecs[i].kind == 1 && vecs[i].pos == 0) begin
        check_output("corner_self", got_data[0], 9);
        check_output("corner_r0c1", got_data[1], 1);
        check_output("corner_r1c0", got_data[16], 1);
        check_output("corner_r1c1", got_data[17], 1);
        check_output("corner_r0c2", got_data[2], 0);
      end
      if (vecs[i].kind == 1 && vecs[i].pos == 15) begin
        check_output("edge_self",   got_data[15], 9);
        check_output("edge_r0c14",  got_data[14], 1);
        check_output("edge_r1c14",  got_data[30], 1);
        check_output("edge_r1c15",  got_data[31], 1);
        check_output("edge_nowrap", got_data[16], 0);
      end
      repeat (3) @(negedge clk);
      check_output("mc_held", int'(mine_count), vecs[i].exp_mc);
    end

    // start pulsed mid-pass must not disturb timing or results
    apply_stimulus(1, 0);
    build_expected();
    run_pass(500, cyc);
    check_output("busy_start_cycle", cyc, PASS_CYCLES);
    check_output("busy_start_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // reset during cycle 100 of a full-bitmap pass
    apply_stimulus(2, 0);
    build_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_pending", exp_q.size(), NCELL - 9);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_output("abort_wren", int'(count_mem_wren), 0);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_mc",   int'(mine_count), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(1, 0);
    build_expected();
    run_pass(-1, cyc);
    check_output("restart_cycle", cyc, PASS_CYCLES);
    check_output("restart_queue", exp_q.size(), 0);
    check_output("restart_cell0", got_data[0], 9);
    repeat (3) @(negedge clk);

    // start held high across DONE launches a second full pass
    apply_stimulus(3, 0);
    build_expected();
    build_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(-1, 1'b1, cyc);
    check_output("hold_first_cycle", cyc, PASS_CYCLES);
    check_output("hold_first_mc", int'(mine_count), 52);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("hold_rebusy", int'(busy), 1);
    wait_done(-1, 1'b0, cyc);
    check_output("hold_second_cycle", cyc, PASS_CYCLES);
    check_output("hold_second_mc", int'(mine_count), 52);
    check_output("hold_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
